// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module : snake_pkg
// Brief  : Grid constants, placer state encoding and bounds helper.
// Rev    : 1.0
// ============================================================================
package snake_pkg;

   localparam int unsigned C_MAX_X     = 160;
   localparam int unsigned C_MAX_Y     = 120;
   localparam int unsigned C_X_W       = 8;
   localparam int unsigned C_Y_W       = 7;
   localparam int unsigned C_RND_W     = C_X_W + C_Y_W;
   localparam int unsigned C_RND_X_MSB = 14;
   localparam int unsigned C_RND_X_LSB = 7;
   localparam int unsigned C_RND_Y_MSB = 6;
   localparam int unsigned C_RND_Y_LSB = 0;
   localparam int unsigned C_RETRY_W   = 4;

   typedef enum logic [2:0] {
      REQ      = 3'd0,
      BOUNDS   = 3'd1,
      OCC_WAIT = 3'd2,
      RETRY    = 3'd3,
      ARMED    = 3'd4
   } placer_state_t;

   // Unsigned compare at full width, so 0 is always a legal coordinate.
   function automatic logic in_bounds(input logic [C_X_W-1:0] x,
                                      input logic [C_Y_W-1:0] y,
                                      input logic [C_X_W-1:0] max_x,
                                      input logic [C_Y_W-1:0] max_y);
      return (x < max_x) && (y < max_y);
   endfunction

endpackage
`default_nettype wire

// File: rtl/target_placer.sv
`default_nettype none
// ============================================================================
// Module : target_placer
// Brief  : Requests random targets, validates bounds/occupancy, detects eats.
// Rev    : 1.0
// ============================================================================
module target_placer
   import snake_pkg::*;
#(
   parameter int unsigned MAX_X       = C_MAX_X,
   parameter int unsigned MAX_Y       = C_MAX_Y,
   parameter int unsigned MAX_RETRIES = 15,
   parameter int unsigned DEFAULT_X   = 80,
   parameter int unsigned DEFAULT_Y   = 60
)(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               TICK,
   input  logic [C_X_W-1:0]   HEAD_X,
   input  logic [C_Y_W-1:0]   HEAD_Y,
   input  logic [C_RND_W-1:0] RND_ADDR,
   output logic               TARGET_ATE,
   output logic               OCC_REQ,
   output logic [C_X_W-1:0]   OCC_X,
   output logic [C_Y_W-1:0]   OCC_Y,
   input  logic               OCC_ACK,
   input  logic               OCC_HIT,
   output logic [C_X_W-1:0]   TARGET_X,
   output logic [C_Y_W-1:0]   TARGET_Y,
   output logic               TARGET_VALID,
   output logic               SCORE_INC
);

   localparam logic [C_X_W-1:0]     c_max_x       = C_X_W'(MAX_X);
   localparam logic [C_Y_W-1:0]     c_max_y       = C_Y_W'(MAX_Y);
   localparam logic [C_X_W-1:0]     c_default_x   = C_X_W'(DEFAULT_X);
   localparam logic [C_Y_W-1:0]     c_default_y   = C_Y_W'(DEFAULT_Y);
   localparam logic [C_RETRY_W-1:0] c_max_retries = C_RETRY_W'(MAX_RETRIES);

   placer_state_t          r_state;
   logic [C_X_W-1:0]       r_cand_x;
   logic [C_Y_W-1:0]       r_cand_y;
   logic [C_X_W-1:0]       r_target_x;
   logic [C_Y_W-1:0]       r_target_y;
   logic                   r_target_valid;
   logic                   r_score_inc;
   logic [C_RETRY_W-1:0]   r_retry_cnt;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state        <= REQ;
         r_cand_x       <= '0;
         r_cand_y       <= '0;
         r_target_x     <= c_default_x;
         r_target_y     <= c_default_y;
         r_target_valid <= 1'b0;
         r_score_inc    <= 1'b0;
         r_retry_cnt    <= '0;
      end else begin
         r_score_inc <= 1'b0;
         case (r_state)
            REQ: begin
               r_cand_x <= RND_ADDR[C_RND_X_MSB:C_RND_X_LSB];
               r_cand_y <= RND_ADDR[C_RND_Y_MSB:C_RND_Y_LSB];
               r_state  <= BOUNDS;
            end
            BOUNDS: begin
               r_state <= in_bounds(r_cand_x, r_cand_y, c_max_x, c_max_y)
                          ? OCC_WAIT : RETRY;
            end
            OCC_WAIT: begin
               if (OCC_ACK) begin
                  if (OCC_HIT) begin
                     r_state <= RETRY;
                  end else begin
                     r_target_x     <= r_cand_x;
                     r_target_y     <= r_cand_y;
                     r_target_valid <= 1'b1;
                     r_retry_cnt    <= '0;
                     r_state        <= ARMED;
                  end
               end
            end
            RETRY: begin
               // Fallback cell is trusted without an occupancy query.
               if (r_retry_cnt == c_max_retries) begin
                  r_target_x     <= c_default_x;
                  r_target_y     <= c_default_y;
                  r_target_valid <= 1'b1;
                  r_retry_cnt    <= '0;
                  r_state        <= ARMED;
               end else begin
                  r_retry_cnt <= r_retry_cnt + 1'b1;
                  r_state     <= REQ;
               end
            end
            ARMED: begin
               if (TICK && (HEAD_X == r_target_x) && (HEAD_Y == r_target_y)) begin
                  r_score_inc    <= 1'b1;
                  r_target_valid <= 1'b0;
                  r_state        <= REQ;
               end
            end
            default: r_state <= REQ;
         endcase
      end
   end

   // Gated by RESET so no request leaks out while reset is held in REQ.
   assign TARGET_ATE   = (r_state == REQ) && !RESET;
   assign OCC_REQ      = (r_state == OCC_WAIT);
   assign OCC_X        = r_cand_x;
   assign OCC_Y        = r_cand_y;
   assign TARGET_X     = r_target_x;
   assign TARGET_Y     = r_target_y;
   assign TARGET_VALID = r_target_valid;
   assign SCORE_INC    = r_score_inc;

endmodule
`default_nettype wire

// File: tb/tb_target_placer.sv
`default_nettype none
// ============================================================================
// Module : tb_target_placer
// Brief  : Directed self-checking bench for target_placer.
// Rev    : 1.0
// ============================================================================
module tb_target_placer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        TICK = 1'b0;
   logic [7:0]  HEAD_X = '0;
   logic [6:0]  HEAD_Y = '0;
   logic [14:0] RND_ADDR = '0;
   logic        OCC_ACK = 1'b0;
   logic        OCC_HIT = 1'b0;
   logic        TARGET_ATE, OCC_REQ, TARGET_VALID, SCORE_INC;
   logic [7:0]  OCC_X, TARGET_X;
   logic [6:0]  OCC_Y, TARGET_Y;

   int n_checks = 0;
   int n_pass   = 0;

   target_placer dut (
      .CLK(CLK), .RESET(RESET), .TICK(TICK), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y),
      .RND_ADDR(RND_ADDR), .TARGET_ATE(TARGET_ATE), .OCC_REQ(OCC_REQ),
      .OCC_X(OCC_X), .OCC_Y(OCC_Y), .OCC_ACK(OCC_ACK), .OCC_HIT(OCC_HIT),
      .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .TARGET_VALID(TARGET_VALID),
      .SCORE_INC(SCORE_INC)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ate(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (TARGET_ATE) begin
            seen = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_occ(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (OCC_REQ) begin
            seen = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Answers an open query one cycle after OCC_REQ rises.
   task automatic serve_occ(input bit hit);
      OCC_ACK = 1'b0;
      step();
      OCC_ACK = 1'b1;
      OCC_HIT = hit;
      step();
      OCC_ACK = 1'b0;
      OCC_HIT = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      step();
      step();
      n_checks++; if (TARGET_X !== 8'd80) $display("FAIL reset_x: got %0d want 80", TARGET_X); else n_pass++;
      n_checks++; if (TARGET_Y !== 7'd60) $display("FAIL reset_y: got %0d want 60", TARGET_Y); else n_pass++;
      n_checks++; if (TARGET_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", TARGET_VALID); else n_pass++;
      n_checks++; if ({TARGET_ATE, OCC_REQ, SCORE_INC} !== 3'b000)
         $display("FAIL reset_strobes: got ate/occ/score=%b want 000", {TARGET_ATE, OCC_REQ, SCORE_INC}); else n_pass++;
      RESET = 1'b0;
      #1;
      n_checks++; if (TARGET_ATE !== 1'b1) $display("FAIL reset_first_ate: got %b want 1", TARGET_ATE); else n_pass++;
   endtask

   task automatic test_accept();
      bit seen;
      RND_ADDR = {8'd10, 7'd20};
      step();
      n_checks++; if (TARGET_ATE !== 1'b0) $display("FAIL accept_ate_pulse: got %b want 0", TARGET_ATE); else n_pass++;
      wait_occ(5, seen);
      n_checks++; if (!seen) $display("FAIL accept_occ_req: got none want OCC_REQ"); else n_pass++;
      n_checks++; if ({OCC_X, OCC_Y} !== {8'd10, 7'd20})
         $display("FAIL accept_occ_xy: got %0d/%0d want 10/20", OCC_X, OCC_Y); else n_pass++;
      serve_occ(1'b0);
      n_checks++; if ({TARGET_X, TARGET_Y, TARGET_VALID} !== {8'd10, 7'd20, 1'b1})
         $display("FAIL accept_target: got %0d/%0d v%b want 10/20 v1", TARGET_X, TARGET_Y, TARGET_VALID); else n_pass++;
      n_checks++; if (OCC_REQ !== 1'b0) $display("FAIL accept_occ_drop: got %b want 0", OCC_REQ); else n_pass++;
   endtask

   task automatic test_no_tick();
      HEAD_X = 8'd10;
      HEAD_Y = 7'd20;
      TICK   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (SCORE_INC !== 1'b0) $display("FAIL notick_score: got %b want 0", SCORE_INC); else n_pass++;
      end
      HEAD_X = 8'd11;
      TICK   = 1'b1;
      step();
      TICK   = 1'b0;
      n_checks++; if ({SCORE_INC, TARGET_VALID} !== 2'b01)
         $display("FAIL mismatch_tick: got score/valid=%b want 01", {SCORE_INC, TARGET_VALID}); else n_pass++;
   endtask

   task automatic test_eat_and_bounds();
      bit seen;
      int occ_seen;
      HEAD_X = 8'd10;
      HEAD_Y = 7'd20;
      TICK   = 1'b1;
      step();
      TICK   = 1'b0;
      n_checks++; if ({SCORE_INC, TARGET_VALID, TARGET_ATE} !== 3'b101)
         $display("FAIL eat_strobes: got score/valid/ate=%b want 101", {SCORE_INC, TARGET_VALID, TARGET_ATE}); else n_pass++;
      n_checks++; if (TARGET_X !== 8'd10) $display("FAIL eat_hold_x: got %0d want 10", TARGET_X); else n_pass++;
      RND_ADDR = {8'd200, 7'd5};
      step();
      n_checks++; if (SCORE_INC !== 1'b0) $display("FAIL eat_one_shot: got %b want 0", SCORE_INC); else n_pass++;
      occ_seen = 0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (TARGET_ATE) begin
            seen = 1'b1;
            break;
         end
         if (OCC_REQ) occ_seen++;
         step();
      end
      n_checks++; if (!seen) $display("FAIL bounds_retry_ate: got none want second TARGET_ATE"); else n_pass++;
      n_checks++; if (occ_seen != 0) $display("FAIL bounds_no_occ: got %0d OCC_REQ cycles want 0", occ_seen); else n_pass++;
      RND_ADDR = {8'd159, 7'd119};
      step();
      wait_occ(5, seen);
      n_checks++; if (!seen || {OCC_X, OCC_Y} !== {8'd159, 7'd119})
         $display("FAIL edge_occ_xy: got %0d/%0d seen%b want 159/119", OCC_X, OCC_Y, seen); else n_pass++;
      serve_occ(1'b0);
      n_checks++; if ({TARGET_X, TARGET_Y, TARGET_VALID} !== {8'd159, 7'd119, 1'b1})
         $display("FAIL edge_target: got %0d/%0d v%b want 159/119 v1", TARGET_X, TARGET_Y, TARGET_VALID); else n_pass++;
   endtask

   task automatic test_back_to_back();
      HEAD_X = 8'd159;
      HEAD_Y = 7'd119;
      TICK   = 1'b1;
      step();
      TICK   = 1'b0;
      n_checks++; if (SCORE_INC !== 1'b1) $display("FAIL b2b_score: got %b want 1", SCORE_INC); else n_pass++;
      RND_ADDR = {8'd30, 7'd40};
      step();
      step();
      n_checks++; if (OCC_REQ !== 1'b1) $display("FAIL b2b_occ_req: got %b want 1", OCC_REQ); else n_pass++;
      step();
      n_checks++; if ({OCC_REQ, TARGET_VALID} !== 2'b10)
         $display("FAIL b2b_wait: got occ/valid=%b want 10", {OCC_REQ, TARGET_VALID}); else n_pass++;
      OCC_ACK = 1'b1;
      step();
      OCC_ACK = 1'b0;
      n_checks++; if ({TARGET_X, TARGET_Y, TARGET_VALID} !== {8'd30, 7'd40, 1'b1})
         $display("FAIL b2b_latency: got %0d/%0d v%b want 30/40 v1 four cycles after score", TARGET_X, TARGET_Y, TARGET_VALID); else n_pass++;
   endtask

   task automatic test_reset_mid_query();
      bit seen;
      HEAD_X = 8'd30;
      HEAD_Y = 7'd40;
      TICK   = 1'b1;
      step();
      TICK   = 1'b0;
      RND_ADDR = {8'd5, 7'd6};
      wait_occ(6, seen);
      n_checks++; if (!seen) $display("FAIL midq_occ_req: got none want OCC_REQ"); else n_pass++;
      RESET = 1'b1;
      step();
      n_checks++; if (OCC_REQ !== 1'b0) $display("FAIL midq_occ_abort: got %b want 0", OCC_REQ); else n_pass++;
      OCC_ACK = 1'b1;
      step();
      OCC_ACK = 1'b0;
      n_checks++; if ({TARGET_X, TARGET_Y, TARGET_VALID} !== {8'd80, 7'd60, 1'b0})
         $display("FAIL midq_defaults: got %0d/%0d v%b want 80/60 v0", TARGET_X, TARGET_Y, TARGET_VALID); else n_pass++;
      RESET = 1'b0;
      #1;
      n_checks++; if (TARGET_ATE !== 1'b1) $display("FAIL midq_req_state: got ate=%b want 1", TARGET_ATE); else n_pass++;
   endtask

   task automatic test_fallback();
      bit seen;
      bit seen_occ;
      int ate_cnt;
      ate_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         wait_ate(10, seen);
         if (!seen) break;
         ate_cnt++;
         RND_ADDR = {8'(k * 9), 7'(k * 7)};
         step();
         wait_occ(5, seen_occ);
         if (seen_occ) serve_occ(1'b1);
      end
      n_checks++; if (TARGET_VALID !== 1'b0) $display("FAIL fallback_early_valid: got %b want 0", TARGET_VALID); else n_pass++;
      for (int i = 0; i < 12; i++) begin
         if (TARGET_VALID) break;
         if (TARGET_ATE) ate_cnt++;
         step();
      end
      n_checks++; if ({TARGET_X, TARGET_Y, TARGET_VALID} !== {8'd80, 7'd60, 1'b1})
         $display("FAIL fallback_target: got %0d/%0d v%b want 80/60 v1", TARGET_X, TARGET_Y, TARGET_VALID); else n_pass++;
      n_checks++; if (ate_cnt != 16) $display("FAIL fallback_ate_count: got %0d want 16", ate_cnt); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_accept();
      test_no_tick();
      test_eat_and_bounds();
      test_back_to_back();
      test_reset_mid_query();
      test_fallback();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/target_placer.md
Name: target_placer

Overview:
- Consumer side of the random-target interface. It requests a random address from the target generator and splits it into column and row.
- Validates each candidate against the play-field bounds and against the snake body via an occupancy query. Latches the accepted target and detects when the snake head eats it.
- Sits between the random-target generator, the snake body store and the VGA/score logic.

Parameters:
- MAX_X, 160, number of columns; valid X range 0..MAX_X-1.
- MAX_Y, 120, number of rows; valid Y range 0..MAX_Y-1.
- MAX_RETRIES, 15, rejected candidates allowed before the fallback is used (4-bit counter).
- DEFAULT_X, 80, fallback and reset target column.
- DEFAULT_Y, 60, fallback and reset target row.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- TICK  in  1  one-cycle game-step strobe.
- HEAD_X  in  8  snake head column, sampled on TICK.
- HEAD_Y  in  7  snake head row, sampled on TICK.
- RND_ADDR  in  15  generator output; [14:7] is the X candidate, [6:0] is the Y candidate; valid only in the cycle TARGET_ATE=1.
- TARGET_ATE  out  1  one-cycle request pulse to the generator.
- OCC_REQ  out  1  occupancy query request.
- OCC_X  out  8  queried column.
- OCC_Y  out  7  queried row.
- OCC_ACK  in  1  occupancy response strobe.
- OCC_HIT  in  1  1 = queried cell is occupied by the body; valid with OCC_ACK.
- TARGET_X  out  8  current target column.
- TARGET_Y  out  7  current target row.
- TARGET_VALID  out  1  target placed and live.
- SCORE_INC  out  1  one-cycle pulse when the target is eaten.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - State goes to REQ.
  - TARGET_X=DEFAULT_X, TARGET_Y=DEFAULT_Y.
  - TARGET_VALID=0, SCORE_INC=0, TARGET_ATE=0, OCC_REQ=0.
  - Retry counter cleared.
  - Reset asserted in any state, including mid-query, aborts that operation. A late OCC_ACK after reset is ignored because the state is not OCC_WAIT.
- REQ:
  - TARGET_ATE=1 for exactly this cycle (Moore output, combinational from state).
  - RND_ADDR is captured into cand_x/cand_y registers on the same edge.
  - Next state is BOUNDS.
- BOUNDS:
  - If cand_x<MAX_X and cand_y<MAX_Y, go to OCC_WAIT.
  - Otherwise it is a reject; go to RETRY.
  - Compares are unsigned at full width; 0 is a legal coordinate.
- OCC_WAIT:
  - OCC_REQ=1, with OCC_X/OCC_Y = cand_x/cand_y held stable until OCC_ACK.
  - OCC_REQ deasserts the cycle after ACK is seen.
  - ACK with HIT=0: accept. Load TARGET_X/Y from the candidate, set TARGET_VALID=1, clear the retry counter, go to ARMED.
  - ACK with HIT=1: reject; go to RETRY.
  - No timeout.
- RETRY:
  - If retry count == MAX_RETRIES, accept the fallback: TARGET_X/Y=DEFAULT_X/Y, TARGET_VALID=1, clear the counter, go to ARMED. The fallback is not occupancy-checked.
  - Otherwise increment the counter and go to REQ.
- ARMED:
  - On TICK with HEAD_X==TARGET_X and HEAD_Y==TARGET_Y: SCORE_INC=1 for exactly one cycle (registered, asserted the cycle after the TICK edge). TARGET_VALID=0 on the same cycle; go to REQ.
  - TICK without a match: no change.
  - Head matches without TICK: ignored.
- Latency:
  - Best case from eat to new target: TICK edge → REQ (1) → BOUNDS (1) → OCC_WAIT (ACK latency + 1) → ARMED.
  - With a 1-cycle ACK, TARGET_VALID returns 4 cycles after SCORE_INC.
- TICK outside ARMED is ignored; an eat cannot occur while TARGET_VALID=0.
- TARGET_X/Y hold their previous value while TARGET_VALID=0.

Decomposition:
- Shared package snake_pkg:
  - Grid constants: MAX_X, MAX_Y, X_W=8, Y_W=7.
  - Placer state enum: REQ, BOUNDS, OCC_WAIT, RETRY, ARMED.
  - RND_ADDR field slice constants.
- No sub-module is needed. The bounds compare is a trivially inline function.

Test Plan:
- Reset: hold RESET for 2 cycles → TARGET_X=80, TARGET_Y=60, TARGET_VALID=0. The first cycle after release has TARGET_ATE=1.
- In-range accept: RND_ADDR={8'd10,7'd20}, OCC ACK after 1 cycle with HIT=0 → OCC_X=10, OCC_Y=20, then TARGET_X=10, TARGET_Y=20, TARGET_VALID=1.
- Bounds reject: first RND_ADDR={8'd200,7'd5} → no OCC_REQ and a second TARGET_ATE pulse. Then {8'd159,7'd119} → accepted at 159/119.
- Occupancy reject and fallback:
  - HIT=1 on 16 consecutive in-range candidates → TARGET_X=80, TARGET_Y=60, TARGET_VALID=1.
  - Exactly 16 TARGET_ATE pulses are seen.
- Eat:
  - Target at 10/20, HEAD=10/20 with TICK → SCORE_INC high for 1 cycle, TARGET_VALID=0, then TARGET_ATE next cycle.
  - HEAD=10/20 without TICK → no SCORE_INC.
- Reset mid-query: assert RESET while OCC_REQ=1, then deliver ACK during reset → state REQ, TARGET_VALID=0, ACK ignored, defaults restored.
